// File: rtl/vga_seq_pkg.sv
// Shared timing defaults, region encoding and the envelope helper for the
// VGA beam sequencer.
package vga_seq_pkg;

  localparam int POS_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL       = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL       = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int FRAME_W_DEF   = 12;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_t;

  // Decaying ramp: 31 at the start of each 16-frame beat, down to 1.
  function automatic logic [4:0] envelope_of(input logic [3:0] n);
    return 5'd31 - {n, 1'b0};
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis (horizontal or vertical): position counter, region FSM and
// registered sync/active flags aligned with the registered position.
module sync_axis_counter
  import vga_seq_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output region_t          region,
  output logic             sync_n,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;
  localparam logic [POS_W-1:0] LAST     = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] FRONT_AT = POS_W'(DISPLAY);
  localparam logic [POS_W-1:0] SYNC_AT  = POS_W'(DISPLAY + FRONT);
  localparam logic [POS_W-1:0] BACK_AT  = POS_W'(DISPLAY + FRONT + SYNC);

  logic [POS_W-1:0] pos_next;
  region_t          region_next;

  // Combinational so the next axis (or frame logic) sees the edge in the same cycle.
  assign wrap = advance && (pos == LAST);

  always_comb begin
    pos_next = pos;
    if (wrap)
      pos_next = '0;
    else if (advance)
      pos_next = pos + POS_W'(1);
  end

  always_comb begin
    region_next = region;
    case (region)
      REG_ACTIVE: if (pos_next == FRONT_AT) region_next = REG_FRONT;
      REG_FRONT:  if (pos_next == SYNC_AT)  region_next = REG_SYNC;
      REG_SYNC:   if (pos_next == BACK_AT)  region_next = REG_BACK;
      REG_BACK:   if (wrap)                 region_next = REG_ACTIVE;
      default:    region_next = region;
    endcase
  end

  // Flags are derived from the next region so they line up with pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= LAST;
      region <= REG_BACK;
      sync_n <= 1'b1;
      active <= 1'b0;
    end else begin
      pos    <= pos_next;
      region <= region_next;
      sync_n <= (region_next != REG_SYNC);
      active <= (region_next == REG_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_beam_sequencer.sv
// 640x480@60 VGA timing plus demo frame/part/beat sequencing.
// Optional PART_OVERRIDE_EN adds part_force/part_sel, latched per frame.
module vga_beam_sequencer
  import vga_seq_pkg::*;
#(
  parameter int H_DISPLAY = vga_seq_pkg::H_DISPLAY_DEF,
  parameter int H_FRONT   = vga_seq_pkg::H_FRONT_DEF,
  parameter int H_SYNC    = vga_seq_pkg::H_SYNC_DEF,
  parameter int H_BACK    = vga_seq_pkg::H_BACK_DEF,
  parameter int V_DISPLAY = vga_seq_pkg::V_DISPLAY_DEF,
  parameter int V_FRONT   = vga_seq_pkg::V_FRONT_DEF,
  parameter int V_SYNC    = vga_seq_pkg::V_SYNC_DEF,
  parameter int V_BACK    = vga_seq_pkg::V_BACK_DEF,
  parameter int FRAME_W   = vga_seq_pkg::FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_counter,
  output logic [2:0]         part,
  output logic [1:0]         beat_phase,
  output logic [4:0]         envelope
`ifdef PART_OVERRIDE_EN
  ,
  input  logic               part_force,
  input  logic [2:0]         part_sel
`endif
);

  logic    h_wrap, v_wrap, h_active, v_active, first_frame;
  region_t h_region, v_region;
  logic    unused_regions;

  assign unused_regions = ^{h_region, v_region};

  sync_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .advance(1'b1), .pos(hpos), .region(h_region),
    .sync_n(hsync), .active(h_active), .wrap(h_wrap)
  );

  sync_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .advance(h_wrap), .pos(vpos), .region(v_region),
    .sync_n(vsync), .active(v_active), .wrap(v_wrap)
  );

  // Both terms are flops aligned to hpos/vpos, so no extra stage is needed.
  assign display_on = h_active & v_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      first_frame   <= 1'b1;
      frame_counter <= '0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) begin
        first_frame <= 1'b0;
        if (run && !first_frame)
          frame_counter <= frame_counter + {{(FRAME_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef PART_OVERRIDE_EN
  logic       force_q;
  logic [2:0] sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_q <= 1'b0;
      sel_q   <= 3'd0;
    end else if (v_wrap) begin
      force_q <= part_force;
      sel_q   <= part_sel;
    end
  end

  assign part = force_q ? sel_q : frame_counter[9:7];
`else
  assign part = frame_counter[9:7];
`endif

  assign beat_phase = frame_counter[5:4];
  assign envelope   = envelope_of(frame_counter[3:0]);

endmodule
